// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths and types for the RiSC16 store buffer slice.
//   Provides the RiSC16 width macros (WORD_LEN, ADDR_LEN) and the default
//   buffer depth (STBUF_DEPTH) when the including build has not already
//   defined them, plus typed aliases used by the interface and modules.
//   Optional feature macro consumed by store_buffer: STBUF_FWD_EN.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 16
`endif
`ifndef STBUF_DEPTH
`define STBUF_DEPTH 4
`endif

package store_buffer_pkg;
  localparam int WORD_W = `WORD_LEN;
  localparam int ADDR_W = `ADDR_LEN;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: core-side store/load bus of the store buffer.
//   st_valid/st_ready/st_addr/st_data : store push handshake (core -> buffer)
//   ld_addr/ld_data/ld_stall          : load lookup (core <-> buffer)
//   master modport = core, slave modport = store buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic  st_valid;
  logic  st_ready;
  addr_t st_addr;
  word_t st_data;
  addr_t ld_addr;
  word_t ld_data;
  logic  ld_stall;

  modport master (
    output st_valid, st_addr, st_data, ld_addr,
    input  st_ready, ld_data, ld_stall
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr,
    output st_ready, ld_data, ld_stall
  );
endinterface

// File: rtl/store_buffer_match.sv
// stbuf_match: load-address lookup against the pending store entries.
//   ldAddr    : load address
//   entryAddr : address held by each entry
//   valid     : entry valid bits
//   tail      : next write slot; the youngest entry sits at tail-1
//   hit       : at least one valid entry matches ldAddr
//   hitIdx    : index of the youngest matching entry
module stbuf_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  addr_t            ldAddr,
  input  addr_t            entryAddr [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PTR_W-1:0] tail,
  output logic             hit,
  output logic [PTR_W-1:0] hitIdx
);

  // Walk from oldest (tail-DEPTH == tail) to youngest (tail-1); the last
  // match assigned wins, which gives youngest-entry priority.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit    = 1'b0;
    hitIdx = '0;
    idx    = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (valid[idx] && (entryAddr[idx] == ldAddr)) begin
        hit    = 1'b1;
        hitIdx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: write-side FIFO in front of the RiSC16 mem_data write port.
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   core             : store_buffer_if.slave (store push + load lookup)
//   mem_readAddr     : mem_data read address (= ld_addr)
//   mem_dataOut      : mem_data read data
//   mem_writeAddr/mem_dataIn/mem_writeEn : mem_data write port (head entry)
//   mem_wr_gnt       : write port granted this cycle
//   empty, count     : occupancy status
//   STBUF_FWD_EN     : when defined, loads hitting a pending store are
//                      forwarded from the youngest match; otherwise the load
//                      stalls until matching stores have drained.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = `STBUF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  store_buffer_if.slave    core,
  output addr_t            mem_readAddr,
  input  word_t            mem_dataOut,
  output addr_t            mem_writeAddr,
  output word_t            mem_dataIn,
  output logic             mem_writeEn,
  input  logic             mem_wr_gnt,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  addr_t            entryAddr [DEPTH];
  word_t            entryData [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             full;
  logic             push;
  logic             pop;
  logic             hit;
  logic [PTR_W-1:0] hitIdx;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = core.st_valid && !full;
  assign pop   = !empty && mem_wr_gnt;

  assign core.st_ready = !full;

  assign mem_writeAddr = entryAddr[head];
  assign mem_dataIn    = entryData[head];
  assign mem_writeEn   = pop;
  assign mem_readAddr  = core.ld_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      entryValid <= '0;
    end else begin
      if (pop) begin
        entryValid[head] <= 1'b0;
        head             <= head + 1'b1;
      end
      if (push) begin
        entryValid[tail] <= 1'b1;
        tail             <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are qualified by entryValid/count.
  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr[tail] <= core.st_addr;
      entryData[tail] <= core.st_data;
    end
  end

  stbuf_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) uMatch (
    .ldAddr    (core.ld_addr),
    .entryAddr (entryAddr),
    .valid     (entryValid),
    .tail      (tail),
    .hit       (hit),
    .hitIdx    (hitIdx)
  );

`ifdef STBUF_FWD_EN
  assign core.ld_data  = hit ? entryData[hitIdx] : mem_dataOut;
  assign core.ld_stall = 1'b0;
`else
  assign core.ld_data  = mem_dataOut;
  assign core.ld_stall = hit && entryValid[hitIdx];
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  addr_t            mem_readAddr;
  word_t            mem_dataOut;
  addr_t            mem_writeAddr;
  word_t            mem_dataIn;
  logic             mem_writeEn;
  logic             mem_wr_gnt;
  logic             empty;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  store_buffer_if coreIf ();

  store_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core          (coreIf.slave),
    .mem_readAddr  (mem_readAddr),
    .mem_dataOut   (mem_dataOut),
    .mem_writeAddr (mem_writeAddr),
    .mem_dataIn    (mem_dataIn),
    .mem_writeEn   (mem_writeEn),
    .mem_wr_gnt    (mem_wr_gnt),
    .empty         (empty),
    .count         (count)
  );

  always #5 clk = ~clk;

  // mem_data model: async read, write on rising edge; every write is logged.
  word_t memArr [0:255];
  addr_t wrAddrLog [$];
  word_t wrDataLog [$];
  addr_t expAddr [$];
  word_t expData [$];

  assign mem_dataOut = memArr[mem_readAddr[7:0]];

  always @(posedge clk) begin
    if (mem_writeEn) begin
      memArr[mem_writeAddr[7:0]] <= mem_dataIn;
      wrAddrLog.push_back(mem_writeAddr);
      wrDataLog.push_back(mem_dataIn);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic checkLog(input string tag);
    check({tag, "_len"}, wrAddrLog.size(), expAddr.size());
    for (int i = 0; i < expAddr.size(); i++) begin
      if (i < wrAddrLog.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wrAddrLog[i], expAddr[i]);
        check($sformatf("%s_data%0d", tag, i), wrDataLog[i], expData[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = '0;
    rst             = 1'b1;
    mem_wr_gnt      = 1'b1;
    coreIf.st_valid = 1'b0;
    coreIf.st_addr  = '0;
    coreIf.st_data  = '0;
    coreIf.ld_addr  = 16'd100;

    // Reset state
    settle();
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_ready", coreIf.st_ready, 1);
    check("rst_wen", mem_writeEn, 0);
    check("rst_stall", coreIf.ld_stall, 0);
    tick();
    rst = 1'b0;
    tick();
    settle();
    check("idle_empty", empty, 1);
    check("idle_wen", mem_writeEn, 0);

    // Fill with grant withheld
    mem_wr_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      coreIf.st_valid = 1'b1;
      coreIf.st_addr  = addr_t'(2 * (i + 1));
      case (i)
        0: coreIf.st_data = 16'd10;
        1: coreIf.st_data = 16'd11;
        2: coreIf.st_data = 16'd14;
        default: coreIf.st_data = 16'd19;
      endcase
      tick();
    end
    coreIf.st_addr = 16'd10;
    coreIf.st_data = 16'd26;
    settle();
    check("full_count", count, 4);
    check("full_ready", coreIf.st_ready, 0);
    check("full_wen_nognt", mem_writeEn, 0);
    tick();
    coreIf.st_valid = 1'b0;
    settle();
    check("full_ignore_count", count, 4);

    // Drain in order
    mem_wr_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("drain_wen%0d", i), mem_writeEn, 1);
      check($sformatf("drain_addr%0d", i), mem_writeAddr, 2 * (i + 1));
      tick();
    end
    expAddr = '{16'd2, 16'd4, 16'd6, 16'd8};
    expData = '{16'd10, 16'd11, 16'd14, 16'd19};
    settle();
    check("drained_empty", empty, 1);
    check("drained_wen", mem_writeEn, 0);
    coreIf.ld_addr = 16'd4;
    settle();
    check("mem_read4", coreIf.ld_data, 11);
    check("mem_read4_stall", coreIf.ld_stall, 0);
    checkLog("log1");

    // Streaming: push every cycle with grant, pointers wrap twice
    for (int i = 0; i < 8; i++) begin
      coreIf.st_valid = 1'b1;
      coreIf.st_addr  = addr_t'(20 + i);
      coreIf.st_data  = word_t'(100 + i);
      expAddr.push_back(addr_t'(20 + i));
      expData.push_back(word_t'(100 + i));
      settle();
      if (i > 0) begin
        check($sformatf("stream_count%0d", i), count, 1);
        check($sformatf("stream_waddr%0d", i), mem_writeAddr, 20 + i - 1);
      end
      tick();
    end
    coreIf.st_valid = 1'b0;
    settle();
    check("stream_tail_count", count, 1);
    tick();
    settle();
    check("stream_end_empty", empty, 1);
    checkLog("log2");

    // Two pending stores to the same address
    mem_wr_gnt = 1'b0;
    coreIf.st_valid = 1'b1;
    coreIf.st_addr  = 16'd6;
    coreIf.st_data  = 16'd14;
    tick();
    coreIf.st_data  = 16'd99;
    tick();
    coreIf.st_valid = 1'b0;
    memArr[6] = 16'd0;
    coreIf.ld_addr = 16'd6;
    settle();
`ifdef STBUF_FWD_EN
    check("fwd_data", coreIf.ld_data, 99);
    check("fwd_stall", coreIf.ld_stall, 0);
`else
    check("nofwd_stall", coreIf.ld_stall, 1);
`endif
    coreIf.ld_addr = 16'd7;
    settle();
    check("miss_stall", coreIf.ld_stall, 0);
    check("miss_data", coreIf.ld_data, 0);
    coreIf.ld_addr = 16'd6;
    mem_wr_gnt = 1'b1;
    tick();
    settle();
`ifdef STBUF_FWD_EN
    check("fwd_half_data", coreIf.ld_data, 99);
`else
    check("nofwd_half_stall", coreIf.ld_stall, 1);
`endif
    tick();
    mem_wr_gnt = 1'b0;
    settle();
    check("dup_drained_stall", coreIf.ld_stall, 0);
    check("dup_drained_data", coreIf.ld_data, 99);
    expAddr.push_back(16'd6); expData.push_back(16'd14);
    expAddr.push_back(16'd6); expData.push_back(16'd99);
    checkLog("log3");

    // Same-cycle push is invisible to the concurrent load
    coreIf.st_valid = 1'b1;
    coreIf.st_addr  = 16'd12;
    coreIf.st_data  = 16'd50;
    coreIf.ld_addr  = 16'd12;
    settle();
    check("samecyc_data", coreIf.ld_data, 0);
    check("samecyc_stall", coreIf.ld_stall, 0);
    tick();
    coreIf.st_valid = 1'b0;
    settle();
`ifdef STBUF_FWD_EN
    check("nextcyc_fwd_data", coreIf.ld_data, 50);
`else
    check("nextcyc_stall", coreIf.ld_stall, 1);
`endif

    // Reset mid-queue with 3 entries discards them
    coreIf.st_valid = 1'b1;
    coreIf.st_addr  = 16'd14;
    coreIf.st_data  = 16'd1;
    tick();
    coreIf.st_addr  = 16'd16;
    coreIf.st_data  = 16'd2;
    tick();
    coreIf.st_valid = 1'b0;
    settle();
    check("pre_rst_count", count, 3);
    rst        = 1'b1;
    mem_wr_gnt = 1'b1;
    #1;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_wen", mem_writeEn, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    settle();
    check("post_rst_wen", mem_writeEn, 0);
    check("post_rst_mem12", memArr[12], 0);
    checkLog("log4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
